// File: rtl/mem_data_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage (P) and a
// loader/debug port (L): fixed priority to P with an anti-starvation forced grant to L.
module mem_data_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic          p_stall,
  output logic          p_ack,
  output logic [DW-1:0] p_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_ack,
  output logic [DW-1:0] l_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P    = 2'd1,
    OWN_L    = 2'd2
  } owner_e;

  owner_e        owner_q, owner_d;
  logic          rd_q, rd_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          force_l;
  logic          l_wins;
  logic          p_gnt;

  // Grants are suppressed while reset is held so nothing reaches the memory.
  always_comb begin
    force_l = (starve_q >= CW'(STARVE_LIMIT));
    l_wins  = l_req & (~p_req | force_l) & ~reset;
    p_gnt   = p_req & ~l_wins & ~reset;
  end

  assign l_gnt   = l_wins;
  assign p_stall = p_req & ~p_gnt;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (p_gnt) begin
      mem_addr  = p_addr;
      mem_wdata = p_wdata;
      mem_write = p_we;
      mem_read  = ~p_we;
    end else if (l_wins) begin
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
      mem_write = l_we;
      mem_read  = ~l_we;
    end
  end

  always_comb begin
    owner_d  = OWN_NONE;
    rd_d     = 1'b0;
    starve_d = '0;
    if (p_gnt) begin
      owner_d = OWN_P;
      rd_d    = ~p_we;
    end else if (l_wins) begin
      owner_d = OWN_L;
      rd_d    = ~l_we;
    end
    // Count consecutive denied cycles of L, saturating at the force threshold.
    if (l_req & ~l_wins) begin
      starve_d = force_l ? starve_q : starve_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      rd_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      rd_q     <= rd_d;
      starve_q <= starve_d;
    end
  end

  assign p_ack   = (owner_q == OWN_P);
  assign l_ack   = (owner_q == OWN_L);
  assign p_rdata = (p_ack && rd_q) ? mem_rdata : '0;
  assign l_rdata = (l_ack && rd_q) ? mem_rdata : '0;

endmodule
